// File: rtl/trig_pkg.sv
// ---------------------------------------------------------------------------
// trig_pkg
// Shared constants and types for the trigger path (stretcher and event
// collector). The default widths describe a two-beam system with 32-bit
// ifclk timestamps.
//
// Contents:
//   NBEAMS_DEFAULT        number of beam trigger lines produced by the stretcher
//   TIME_BITS_DEFAULT     width of the free-running event timestamp
//   HOLDOFF_BITS_DEFAULT  width of the per-beam holdoff count
//   OVF_BITS_DEFAULT      width of the dropped-event counter
//   trig_event_t          one event word: beams in the MSBs, timestamp below
// ---------------------------------------------------------------------------
package trig_pkg;

  localparam int NBEAMS_DEFAULT       = 2;
  localparam int TIME_BITS_DEFAULT    = 32;
  localparam int HOLDOFF_BITS_DEFAULT = 8;
  localparam int OVF_BITS_DEFAULT     = 16;

  // Layout of an event as it leaves the collector. Beams that fired in the
  // same cycle share a single event, so beams is a mask rather than an index.
  typedef struct packed {
    logic [NBEAMS_DEFAULT-1:0]    beams;
    logic [TIME_BITS_DEFAULT-1:0] timestamp;
  } trig_event_t;

  localparam int EVENT_BITS_DEFAULT = $bits(trig_event_t);

endpackage

// File: rtl/trig_event_collector_if.sv
// ---------------------------------------------------------------------------
// trig_event_collector_if
// Stream-style valid/ready channel carrying trigger events.
//
// Signals:
//   tdata   {beams[NBEAMS-1:0], timestamp[TIME_BITS-1:0]}, beams in MSBs
//   tvalid  event present on tdata
//   tready  consumer accepts the event this cycle
//
// Modports:
//   master  event producer (the collector)
//   slave   event consumer
// ---------------------------------------------------------------------------
interface trig_event_collector_if
  import trig_pkg::*;
#(
  parameter int NBEAMS    = NBEAMS_DEFAULT,
  parameter int TIME_BITS = TIME_BITS_DEFAULT
);

  logic [NBEAMS+TIME_BITS-1:0] tdata;
  logic                        tvalid;
  logic                        tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/trig_evt_buf.sv
// ---------------------------------------------------------------------------
// trig_evt_buf
// Generic 2-entry FIFO whose head entry is held in registers, so the output
// side (dout/valid) has no combinational path from the push side.
//
// Ports:
//   clk    clock
//   rst    synchronous active-high reset, empties the buffer
//   push   offer din this cycle
//   din    word to store
//   drop   strobe: push offered while full with no pop, word discarded
//   dout   head entry
//   valid  head entry is occupied
//   ready  consumer takes the head entry when valid
// ---------------------------------------------------------------------------
module trig_evt_buf #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             drop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  input  logic             ready
);

  logic [WIDTH-1:0] data0_q, data1_q;
  logic [WIDTH-1:0] data0_n, data1_n;
  logic             valid0_q, valid1_q;
  logic             valid0_n, valid1_n;
  logic             pop;
  logic             push_ok;

  // Entry 1 can only be occupied behind entry 0, so valid1_q alone means full.
  // A pop in the same cycle frees a slot, which lets a push into a full
  // buffer still succeed.
  assign pop     = valid0_q & ready;
  assign push_ok = push & (~valid1_q | pop);
  assign drop    = push & valid1_q & ~pop;

  // Shift first for a pop, then place an accepted word in the first free
  // slot; this keeps arrival order without any pointer logic.
  always_comb begin
    data0_n  = data0_q;
    data1_n  = data1_q;
    valid0_n = valid0_q;
    valid1_n = valid1_q;
    if (pop) begin
      data0_n  = data1_q;
      valid0_n = valid1_q;
      valid1_n = 1'b0;
    end
    if (push_ok) begin
      if (!valid0_n) begin
        data0_n  = din;
        valid0_n = 1'b1;
      end else begin
        data1_n  = din;
        valid1_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data0_q  <= '0;
      data1_q  <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
    end else begin
      data0_q  <= data0_n;
      data1_q  <= data1_n;
      valid0_q <= valid0_n;
      valid1_q <= valid1_n;
    end
  end

  assign dout  = data0_q;
  assign valid = valid0_q;

endmodule

// File: rtl/trig_event_collector.sv
// ---------------------------------------------------------------------------
// trig_event_collector
// Turns per-beam stretched trigger levels (ifclk domain) into discrete,
// timestamped events. Each beam has an enable mask and a programmable
// holdoff; accepted beams in the same cycle share one event. Events leave
// through a 2-entry buffer, and events that arrive while the buffer is full
// and stalled are counted as dropped.
//
// Ports:
//   ifclk        sole clock
//   ifclk_rst    synchronous active-high reset
//   trig_i       stretched trigger levels
//   mask_i       1 = beam disabled
//   holdoff_i    cycles a beam stays blind after an accept
//   m            event stream (master): tdata = {beams, timestamp}
//   ovf_count_o  dropped events, saturating
//   ovf_clr_i    synchronous clear of ovf_count_o (wins over a drop)
// ---------------------------------------------------------------------------
module trig_event_collector
  import trig_pkg::*;
#(
  parameter int NBEAMS       = NBEAMS_DEFAULT,
  parameter int HOLDOFF_BITS = HOLDOFF_BITS_DEFAULT,
  parameter int TIME_BITS    = TIME_BITS_DEFAULT,
  parameter int OVF_BITS     = OVF_BITS_DEFAULT
) (
  input  logic                    ifclk,
  input  logic                    ifclk_rst,
  input  logic [NBEAMS-1:0]       trig_i,
  input  logic [NBEAMS-1:0]       mask_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  trig_event_collector_if.master  m,
  output logic [OVF_BITS-1:0]     ovf_count_o,
  input  logic                    ovf_clr_i
);

  localparam int EVT_BITS = NBEAMS + TIME_BITS;

  logic [TIME_BITS-1:0]    ts_cnt;
  logic [TIME_BITS-1:0]    ts_q;
  logic [NBEAMS-1:0]       trig_q;
  logic [HOLDOFF_BITS-1:0] hold_cnt [NBEAMS];
  logic [NBEAMS-1:0]       acc;
  logic                    evt_valid_q;
  logic [EVT_BITS-1:0]     evt_q;
  logic                    buf_drop;
  logic [EVT_BITS-1:0]     buf_dout;
  logic                    buf_valid;
  logic [OVF_BITS-1:0]     ovf_cnt_q;

  // Free-running timestamp; wraps naturally from all-ones to zero.
  always_ff @(posedge ifclk) begin
    if (ifclk_rst) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + TIME_BITS'(1);
    end
  end

  // Input stage: the trigger levels and the timestamp of the same edge are
  // captured together, so the event carries the time the level was seen.
  always_ff @(posedge ifclk) begin
    if (ifclk_rst) begin
      trig_q <= '0;
      ts_q   <= '0;
    end else begin
      trig_q <= trig_i;
      ts_q   <= ts_cnt;
    end
  end

  // A beam is accepted only when enabled and out of holdoff.
  always_comb begin
    acc = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      acc[b] = trig_q[b] & ~mask_i[b] & (hold_cnt[b] == '0);
    end
  end

  // Holdoff reload on accept (so the next accept is holdoff_i+1 cycles
  // later), otherwise count down to zero. Masked beams never accept, so
  // they only ever count down. A dropped event still reloads here.
  always_ff @(posedge ifclk) begin
    if (ifclk_rst) begin
      for (int b = 0; b < NBEAMS; b++) begin
        hold_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NBEAMS; b++) begin
        if (acc[b]) begin
          hold_cnt[b] <= holdoff_i;
        end else if (hold_cnt[b] != '0) begin
          hold_cnt[b] <= hold_cnt[b] - HOLDOFF_BITS'(1);
        end
      end
    end
  end

  // Event register between the accept logic and the buffer; keeps the
  // buffer push fully registered and sets the two-edge trigger-to-valid
  // latency.
  always_ff @(posedge ifclk) begin
    if (ifclk_rst) begin
      evt_valid_q <= 1'b0;
      evt_q       <= '0;
    end else begin
      evt_valid_q <= |acc;
      evt_q       <= {acc, ts_q};
    end
  end

  trig_evt_buf #(
    .WIDTH(EVT_BITS)
  ) u_buf (
    .clk  (ifclk),
    .rst  (ifclk_rst),
    .push (evt_valid_q),
    .din  (evt_q),
    .drop (buf_drop),
    .dout (buf_dout),
    .valid(buf_valid),
    .ready(m.tready)
  );

  assign m.tdata  = buf_dout;
  assign m.tvalid = buf_valid;

  // Dropped-event counter: saturates at all-ones; a clear in the same cycle
  // as a drop leaves it at zero.
  always_ff @(posedge ifclk) begin
    if (ifclk_rst) begin
      ovf_cnt_q <= '0;
    end else if (ovf_clr_i) begin
      ovf_cnt_q <= '0;
    end else if (buf_drop && (ovf_cnt_q != '1)) begin
      ovf_cnt_q <= ovf_cnt_q + OVF_BITS'(1);
    end
  end

  assign ovf_count_o = ovf_cnt_q;

endmodule

// File: doc/trig_event_collector.md
# trig_event_collector

Single-clock block in the ifclk domain that consumes the per-beam trigger levels produced by the aclk→ifclk stretcher and turns them into discrete, timestamped trigger events. It applies a per-beam enable mask and a programmable per-beam holdoff, then stamps each event with a free-running ifclk timestamp. Events leave on an AXI4-Stream-style valid/ready interface through a 2-entry buffer. Lost events are counted when the downstream consumer stalls.

## Interface
Parameters:
- NBEAMS, 2, number of beam trigger lines (matches the stretcher)
- HOLDOFF_BITS, 8, width of holdoff count
- TIME_BITS, 32, width of timestamp
- OVF_BITS, 16, width of overflow counter

Ports:
- ifclk  in  1  sole clock
- ifclk_rst  in  1  reset; synchronous, active-high
- trig_i  in  NBEAMS  stretched trigger levels, ifclk domain
- mask_i  in  NBEAMS  1 = beam disabled
- holdoff_i  in  HOLDOFF_BITS  holdoff length in ifclk cycles
- m_tdata  out  NBEAMS+TIME_BITS  {beams[NBEAMS-1:0], timestamp[TIME_BITS-1:0]}, beams in MSBs
- m_tvalid  out  1  event valid
- m_tready  in  1  consumer accepts
- ovf_count_o  out  OVF_BITS  events dropped, saturating
- ovf_clr_i  in  1  synchronous clear of ovf_count_o

## Operation
- Input stage: trig_i is registered into trig_q. In the same cycle, the timestamp counter value is registered into ts_q.
- Timestamp: free-running TIME_BITS counter. It increments every cycle and wraps from all-ones to 0.
- Accept rule, per beam b: acc[b] = trig_q[b] & ~mask_i[b] & (hold_cnt[b]==0).
- Holdoff: when acc[b] is set, hold_cnt[b] loads holdoff_i, sampled in that cycle. Otherwise a nonzero hold_cnt[b] decrements.
  - The beam can be accepted again holdoff_i+1 cycles after the previous accept.
  - holdoff_i=0 is level mode: every high cycle is an event.
- Masked beams never load holdoff. Their hold_cnt keeps counting down.
- Event formation: if |acc, push {acc, ts_q} into the buffer. Beams accepted in the same cycle share one event.
- Buffer: 2 entries. Entry 0 drives m_tdata/m_tvalid directly from registers (no combinational path from trig_i).
  - Pop occurs when m_tvalid & m_tready.
  - Push with buffer not full, or full with a simultaneous pop: accepted, order preserved.
  - Push when full with no pop: event dropped. ovf_count_o increments, saturating at all-ones. Holdoff still loads, as if accepted.
- ovf_clr_i: clears the counter. If a drop occurs in the same cycle, clear wins and the result is 0.
- m_tdata is stable while m_tvalid=1 and m_tready=0.

## Timing
- Reset values: m_tvalid=0, m_tdata=0, ovf_count_o=0, timestamp=0, trig_q=0, all hold_cnt=0, buffer empty.
- Reset mid-operation: buffered events are discarded and all holdoffs abort. The first cycle after reset behaves as after power-up.
- Latency: trig_i high at edge N (sampled) → m_tvalid=1 after edge N+2, with an empty buffer. Timestamp field = counter value at edge N.
- Back-to-back: one event per cycle is sustained while m_tready=1.
- Holdoff counts ifclk cycles; one ifclk cycle is one stretcher aclk-group.

## Structure
- Shared package trig_pkg:
  - typedef trig_event_t, the {beams, timestamp} packed struct, parameterized by package constants NBEAMS_DEFAULT and TIME_BITS_DEFAULT.
  - The same package holds the stretcher's NBEAMS constant.
- Sub-module trig_evt_buf: a generic 2-entry registered-output FIFO with valid/ready out, push/full in, and a drop strobe output. Everything else (input register, holdoff, timestamp, overflow counter) is top level.

## Test plan
- Reset, then trig_i=2'b01 for 1 cycle at timestamp 10, holdoff_i=0, m_tready=1 → one event, m_tdata={2'b01, 32'd10}, m_tvalid 2 cycles after sampling.
- holdoff_i=3, trig_i[0] held high 10 cycles starting at ts 20 → events at ts 20, 24, 28; none in between.
- mask_i=2'b10, trig_i=2'b11 one cycle → single event, beams=2'b01.
- m_tready=0, three single-cycle triggers with gaps → first two events delivered in order once ready rises, third dropped; ovf_count_o=1.
- Buffer full, with push and pop in the same cycle → no drop; the new event is delivered after the remaining one.
- ovf_count_o at 16'hFFFF plus another drop → stays 16'hFFFF. ovf_clr_i together with a drop → 0.
- Timestamp wrap: trigger at ts 32'hFFFFFFFF and at the next cycle (holdoff 0) → events stamped FFFFFFFF then 0.
- Assert ifclk_rst while 2 events are buffered → m_tvalid=0 the next cycle; nothing delivered afterwards.
